// File: rtl/frac_block_feeder_pkg.sv
// Shared constants and types for the 8x8 row-streaming interface between the
// frame-buffer feeder and the fractional MV search engine.
package frac_block_feeder_pkg;

  localparam int ROWS       = 8;
  localparam int PIX_W      = 8;
  localparam int ROW_W      = 64;
  localparam int ADDR_W_DEF = 16;
  localparam int ROW_IDX_W  = 3;

  typedef logic [ROW_IDX_W-1:0] row_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_t;

endpackage

// File: rtl/frac_addr_gen.sv
// Latches the current/reference block base addresses on load and turns a row
// index into the pair of word addresses for that row (all arithmetic wraps).
module frac_addr_gen
  import frac_block_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STRIDE = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] blk_x,
  input  logic [ADDR_W-1:0] blk_y,
  input  logic [ADDR_W-1:0] ref_off,
  input  row_idx_t          row,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] ref_addr
);

  localparam logic [ADDR_W-1:0] BLK_STEP = ADDR_W'(ROWS * STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE);

  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] ref_base;
  logic [ADDR_W-1:0] cur_base_nxt;
  logic [ADDR_W-1:0] row_off;

  // ref_off is two's complement, so a plain modular add gives the signed offset
  assign cur_base_nxt = blk_y * BLK_STEP + blk_x;
  assign row_off      = {{(ADDR_W-ROW_IDX_W){1'b0}}, row} * ROW_STEP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_base <= '0;
      ref_base <= '0;
    end else if (load) begin
      cur_base <= cur_base_nxt;
      ref_base <= cur_base_nxt + ref_off;
    end
  end

  assign cur_addr = cur_base + row_off;
  assign ref_addr = ref_base + row_off;

endmodule

// File: rtl/frac_block_feeder.sv
// Fetches one 8x8 current/reference block pair from the frame memories and
// streams it one row per cycle to the fractional search engine.
//
// state | meaning
// IDLE  | waiting for start; bases latched when start is accepted
// ISSUE | one cur/ref read pair per cycle, rows 0..7 in order
// DRAIN | reads finished, waiting for the last row to be emitted
// DONE  | one-cycle done pulse; start ignored
module frac_block_feeder
  import frac_block_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STRIDE = 40,
  parameter int RD_LAT = 1,
  parameter int ROWS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] blk_x,
  input  logic [ADDR_W-1:0] blk_y,
  input  logic [ADDR_W-1:0] ref_off,
  output logic              cur_rd_en,
  output logic [ADDR_W-1:0] cur_rd_addr,
  input  logic [ROW_W-1:0]  cur_rd_data,
  output logic              ref_rd_en,
  output logic [ADDR_W-1:0] ref_rd_addr,
  input  logic [ROW_W-1:0]  ref_rd_data,
  output logic [ROW_W-1:0]  filter_pix,
  output logic [ROW_W-1:0]  ref_pix,
  output logic              input_ready,
  output logic              busy,
  output logic              done
);

  localparam row_idx_t LAST_ROW = ROW_IDX_W'(ROWS - 1);
  localparam row_idx_t ROW_INC  = ROW_IDX_W'(1);

  feed_state_t       state;
  feed_state_t       state_nxt;
  row_idx_t          issue_row;
  row_idx_t          emit_row;
  logic [RD_LAT-1:0] vld_pipe;
  logic              rd_ret;
  logic              last_emit;
  logic              rd_en;
  logic              load;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] ref_addr;

  frac_addr_gen #(
    .ADDR_W (ADDR_W),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .blk_x    (blk_x),
    .blk_y    (blk_y),
    .ref_off  (ref_off),
    .row      (issue_row),
    .cur_addr (cur_addr),
    .ref_addr (ref_addr)
  );

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    load      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        if (issue_row == LAST_ROW) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_emit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cur_rd_en   = rd_en;
  assign ref_rd_en   = rd_en;
  assign cur_rd_addr = rd_en ? cur_addr : '0;
  assign ref_rd_addr = rd_en ? ref_addr : '0;

  // A read's valid bit leaves the pipe in the cycle its data is on the bus
  assign rd_ret = vld_pipe[RD_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      issue_row   <= '0;
      emit_row    <= '0;
      vld_pipe    <= '0;
      last_emit   <= 1'b0;
      input_ready <= 1'b0;
      filter_pix  <= '0;
      ref_pix     <= '0;
    end else begin
      state       <= state_nxt;
      vld_pipe    <= RD_LAT'({vld_pipe, rd_en});
      input_ready <= rd_ret;
      last_emit   <= rd_ret && (emit_row == LAST_ROW);
      if (rd_en) issue_row <= issue_row + ROW_INC;
      if (rd_ret) begin
        emit_row   <= emit_row + ROW_INC;
        filter_pix <= cur_rd_data;
        ref_pix    <= ref_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_frac_block_feeder.sv
// Self-checking bench for frac_block_feeder: two instances (read latency 1 and 3)
// driven with directed and random block requests against a per-cycle schedule model.
module tb_frac_block_feeder;
  import frac_block_feeder_pkg::*;

  localparam int AW     = 16;
  localparam int STRIDE = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int ln, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s lane=%0d cyc=%0d actual=%0h required=%0h", nm, ln, cyc, act, req);
    end
  endtask

  function automatic logic [63:0] mem_cur(input logic [AW-1:0] a);
    return {a, ~a, a ^ 16'h5a5a, a + 16'h1234};
  endfunction

  function automatic logic [63:0] mem_ref(input logic [AW-1:0] a);
    return {a ^ 16'hc3c3, a + 16'h0077, ~a, a};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT      = (g == 0) ? 1 : 3;
    localparam int FIRST_IR = (g == 0) ? 3 : 5;

    logic          reset   = 1'b1;
    logic          start   = 1'b0;
    logic [AW-1:0] blk_x   = '0;
    logic [AW-1:0] blk_y   = '0;
    logic [AW-1:0] ref_off = '0;
    logic          cur_rd_en, ref_rd_en, input_ready, busy, done;
    logic [AW-1:0] cur_rd_addr, ref_rd_addr;
    logic [63:0]   cur_rd_data, ref_rd_data, filter_pix, ref_pix;

    frac_block_feeder #(.ADDR_W(AW), .STRIDE(STRIDE), .RD_LAT(LAT), .ROWS(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .blk_x(blk_x), .blk_y(blk_y), .ref_off(ref_off),
      .cur_rd_en(cur_rd_en), .cur_rd_addr(cur_rd_addr), .cur_rd_data(cur_rd_data),
      .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
      .filter_pix(filter_pix), .ref_pix(ref_pix),
      .input_ready(input_ready), .busy(busy), .done(done)
    );

    // Memory: data for a read appears LAT cycles later, random junk otherwise
    logic          v_q  [LAT] = '{default: 1'b0};
    logic [AW-1:0] ca_q [LAT] = '{default: '0};
    logic [AW-1:0] ra_q [LAT] = '{default: '0};
    logic [63:0]   junk = '0;
    always @(posedge clk) begin
      junk    <= {$urandom, $urandom};
      v_q[0]  <= cur_rd_en;
      ca_q[0] <= cur_rd_addr;
      ra_q[0] <= ref_rd_addr;
      for (int k = 1; k < LAT; k++) begin
        v_q[k]  <= v_q[k-1];
        ca_q[k] <= ca_q[k-1];
        ra_q[k] <= ra_q[k-1];
      end
    end
    assign cur_rd_data = v_q[LAT-1] ? mem_cur(ca_q[LAT-1]) : junk;
    assign ref_rd_data = v_q[LAT-1] ? mem_ref(ra_q[LAT-1]) : ~junk;

    // Expected activity keyed by cycle number
    logic [AW-1:0] e_ca [int];
    logic [AW-1:0] e_ra [int];
    logic [63:0]   e_fp [int];
    logic [63:0]   e_rp [int];
    int b_start = -1;
    int b_end   = -1;
    bit run = 1'b0;
    bit fin = 1'b0;

    logic [63:0] hold_f = '0;
    logic [63:0] hold_r = '0;
    always @(negedge clk) begin
      bit x_rd, x_ir, x_busy, x_done;
      if (run) begin
        x_rd   = e_ca.exists(cyc);
        x_ir   = e_fp.exists(cyc);
        x_busy = (cyc >= b_start) && (cyc <= b_end);
        x_done = (cyc == b_end);
        if (!reset) begin
          hold_f = '0;
          hold_r = '0;
        end else if (x_ir) begin
          hold_f = e_fp[cyc];
          hold_r = e_rp[cyc];
        end
        check("cur_rd_en", g, 64'(cur_rd_en), 64'(x_rd));
        check("ref_rd_en", g, 64'(ref_rd_en), 64'(x_rd));
        if (x_rd) begin
          check("cur_rd_addr", g, 64'(cur_rd_addr), 64'(e_ca[cyc]));
          check("ref_rd_addr", g, 64'(ref_rd_addr), 64'(e_ra[cyc]));
        end
        check("input_ready", g, 64'(input_ready), 64'(x_ir));
        check("filter_pix", g, filter_pix, hold_f);
        check("ref_pix", g, ref_pix, hold_r);
        check("busy", g, 64'(busy), 64'(x_busy));
        check("done", g, 64'(done), 64'(x_done));
      end
    end

    task automatic clr_model();
      e_ca.delete();
      e_ra.delete();
      e_fp.delete();
      e_rp.delete();
      b_start = -1;
      b_end   = -1;
    endtask

    task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic do_reset(input int n);
      reset = 1'b0;
      start = 1'b0;
      clr_model();
      repeat (n) @(posedge clk);
      #1 reset = 1'b1;
    endtask

    // Pulse start for one cycle; the model schedules the block only if idle
    task automatic req(input logic [AW-1:0] x, input logic [AW-1:0] y,
                       input logic [AW-1:0] off);
      int s;
      logic [AW-1:0] cb, rb, ca, ra;
      s = cyc;
      blk_x = x; blk_y = y; ref_off = off; start = 1'b1;
      if (s > b_end) begin
        cb = AW'(int'(y) * 8 * STRIDE + int'(x));
        rb = cb + off;
        for (int r = 0; r < 8; r++) begin
          ca = cb + AW'(r * STRIDE);
          ra = rb + AW'(r * STRIDE);
          e_ca[s+1+r]     = ca;
          e_ra[s+1+r]     = ra;
          e_fp[s+2+LAT+r] = mem_cur(ca);
          e_rp[s+2+LAT+r] = mem_ref(ra);
        end
        b_start = s + 1;
        b_end   = s + 10 + LAT;
      end
      @(posedge clk);
      #1 start = 1'b0;
    endtask

    initial begin
      int e;
      #1;
      run = 1'b1;
      do_reset(2);

      // reset in the middle of issuing row 3
      req(16'd2, 16'd1, 16'd0);
      step(3);
      reset = 1'b0;
      clr_model();
      @(negedge clk);
      check("rst_rd_en", g, 64'(cur_rd_en), 64'd0);
      check("rst_input_ready", g, 64'(input_ready), 64'd0);
      check("rst_busy", g, 64'(busy), 64'd0);
      check("rst_done", g, 64'(done), 64'd0);
      step(2);
      reset = 1'b1;
      @(negedge clk);
      check("rst_release_idle", g, 64'(busy), 64'd0);
      step(1);

      // basic block, literal addresses and first-row latency
      req(16'd2, 16'd1, 16'd0);
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == 1) check("lit_cur_addr_row0", g, 64'(cur_rd_addr), 64'd322);
        if (k == 8) check("lit_cur_addr_row7", g, 64'(cur_rd_addr), 64'd602);
        if (k == FIRST_IR - 1) check("lit_ir_before", g, 64'(input_ready), 64'd0);
        if (k == FIRST_IR) check("lit_ir_first", g, 64'(input_ready), 64'd1);
        if (k == FIRST_IR + 7) check("lit_ir_last", g, 64'(input_ready), 64'd1);
        if (k == FIRST_IR + 8) check("lit_done", g, 64'(done), 64'd1);
      end
      step(1);

      // wrap of base and negative reference offset
      req(16'd65530, 16'd0, 16'hFFD7);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (k == 1) check("lit_ref_addr_row0", g, 64'(ref_rd_addr), 64'd65489);
        if (k == 2) check("lit_cur_addr_wrap", g, 64'(cur_rd_addr), 64'd34);
        if (k == 3) check("lit_ref_addr_wrap", g, 64'(ref_rd_addr), 64'd33);
      end
      step(14);

      // start while busy and in the done cycle
      req(16'd5, 16'd3, 16'd7);
      step(2);
      req(16'd9, 16'd9, 16'd9);
      e = b_end;
      while (cyc < e) step(1);
      req(16'd1, 16'd1, 16'd1);
      @(negedge clk);
      check("lit_ignored_in_done", g, 64'(busy), 64'd0);
      step(3);

      // back-to-back: start on the cycle after done
      req(16'd3, 16'd2, 16'd5);
      e = b_end;
      while (cyc < e + 1) step(1);
      req(16'd4, 16'd2, 16'hFFF0);
      @(negedge clk);
      check("lit_b2b_accepted", g, 64'(busy), 64'd1);
      step(16);

      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 14));
        if ($urandom_range(0, 19) == 0) do_reset(1 + $urandom_range(0, 2));
        else req(AW'($urandom), AW'($urandom_range(0, 300)), AW'($urandom));
      end
      step(20);
      fin = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(lane[0].fin && lane[1].fin) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    check("finish_in_time", 0, 64'(lane[0].fin && lane[1].fin), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
